// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in / parallel-out deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sipo_pkg;

   // Receive FSM states; PARITY is only entered when SIPO_PARITY_EN is defined.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   // Bit counter width able to hold the value WIDTH.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial link input plus parallel valid/ready output of the deserializer.
// Latency: n/a (wires only).
// Backpressure: dout_ready from the consumer side; the serial side has none.
//   master : link driver / consumer (drives clken, si, sof, dout_ready)
//   slave  : deserializer (drives dout, dout_valid, frame_abort, overrun, parity_err)
interface sipo_deserializer_if #(
   parameter int WIDTH = 8
);
   logic             clken;
   logic             si;
   logic             sof;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             frame_abort;
   logic             overrun;
   logic             parity_err;

   modport master (
      output clken, si, sof, dout_ready,
      input  dout, dout_valid, frame_abort, overrun, parity_err
   );

   modport slave (
      input  clken, si, sof, dout_ready,
      output dout, dout_valid, frame_abort, overrun, parity_err
   );
endinterface

// File: rtl/sipo_out_stage.sv
// Single-entry valid/ready holding register for assembled words, with sticky overrun.
// Latency: a word offered on in_vld is visible on out_vld/out_dat the next clk.
// Backpressure: none upstream; a word arriving while full and not being drained is dropped and sets overrun.
//   ports: clk, rst, in_vld/in_dat/in_par (word strobe), out_vld/out_rdy/out_dat/out_par, overrun
module sipo_out_stage
   import sipo_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_dat,
   input  logic             in_par,
   output logic [WIDTH-1:0] out_dat,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic             out_par,
   output logic             overrun
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_dat <= '0;
         out_vld <= 1'b0;
         out_par <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (in_vld) begin
            // The slot is free either when empty or when it drains on this very edge.
            if (!out_vld || out_rdy) begin
               out_dat <= in_dat;
               out_par <= in_par;
               out_vld <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (out_vld && out_rdy) begin
            out_vld <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Assembles a clken-qualified serial stream framed by sof into WIDTH-bit words.
// Latency: dout_valid rises one clk after the last bit (or the parity bit with SIPO_PARITY_EN) is sampled.
// Backpressure: one holding word; a completed word is dropped (overrun set) if the previous one is still unread.
//   ports: clk, rst (async, active-high), bus (slave modport: clken/si/sof in, dout/dout_valid/dout_ready,
//          frame_abort, overrun, parity_err). Optional macro SIPO_PARITY_EN adds an even-parity bit per frame.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   sipo_deserializer_if.slave  bus
);

   localparam int CNT_W = cnt_w(WIDTH);
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t LAST_BIT = cnt_t'(WIDTH - 1);
   localparam cnt_t ONE      = cnt_t'(1);

   state_t           state;
   cnt_t             cnt;
   logic [WIDTH-1:0] shreg;
   logic             abort_q;

   logic [WIDTH-1:0] shift_nxt;
   logic [WIDTH-1:0] first_bit;
   logic             word_vld;
   logic [WIDTH-1:0] word_dat;
   logic             word_par;

   // MSB-first shifts left with si entering bit 0; LSB-first shifts right with si entering
   // the top bit. Either way the first bit ends up at its final position after WIDTH samples.
   always_comb begin
      shift_nxt = '0;
      first_bit = '0;
      if (MSB_FIRST) begin
         shift_nxt = {shreg[WIDTH-2:0], bus.si};
         first_bit = {{(WIDTH-1){1'b0}}, bus.si};
      end else begin
         shift_nxt = {bus.si, shreg[WIDTH-1:1]};
         first_bit = {bus.si, {(WIDTH-1){1'b0}}};
      end
   end

   // Completion strobe: the word is handed to the output stage on the same edge that samples
   // the final bit, so it is taken from the next-shift value rather than the register.
   always_comb begin
      word_vld = 1'b0;
      word_dat = '0;
      word_par = 1'b0;
`ifdef SIPO_PARITY_EN
      word_vld = bus.clken & ~bus.sof & (state == PARITY);
      word_dat = shreg;
      // Even parity: data bits XOR parity bit must be zero for a clean frame.
      word_par = (^shreg) ^ bus.si;
`else
      word_vld = bus.clken & ~bus.sof & (state == SHIFT) & (cnt == LAST_BIT);
      word_dat = shift_nxt;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         shreg   <= '0;
         abort_q <= 1'b0;
      end else begin
         abort_q <= 1'b0;
         if (bus.clken) begin
            case (state)
               IDLE: begin
                  if (bus.sof) begin
                     shreg <= first_bit;
                     cnt   <= ONE;
                     state <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (bus.sof) begin
                     // Restart: partial word is discarded, si is the new bit 0.
                     shreg   <= first_bit;
                     cnt     <= ONE;
                     abort_q <= 1'b1;
                  end else begin
                     shreg <= shift_nxt;
                     if (cnt == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
                        cnt   <= cnt + ONE;
                        state <= PARITY;
`else
                        cnt   <= '0;
                        state <= IDLE;
`endif
                     end else begin
                        cnt <= cnt + ONE;
                     end
                  end
               end
`ifdef SIPO_PARITY_EN
               PARITY: begin
                  if (bus.sof) begin
                     shreg   <= first_bit;
                     cnt     <= ONE;
                     state   <= SHIFT;
                     abort_q <= 1'b1;
                  end else begin
                     cnt   <= '0;
                     state <= IDLE;
                  end
               end
`endif
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.frame_abort = abort_q;

   sipo_out_stage #(
      .WIDTH (WIDTH)
   ) u_out_stage (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (word_vld),
      .in_dat  (word_dat),
      .in_par  (word_par),
      .out_dat (bus.dout),
      .out_vld (bus.dout_valid),
      .out_rdy (bus.dout_ready),
      .out_par (bus.parity_err),
      .overrun (bus.overrun)
   );

endmodule
